// File: rtl/serial_subtractor_if.sv
// Bundle of request/response signals for serial_subtractor.
// start is a request sampled at a rising edge only while busy=0; done is a one-cycle response carrying diff/bout/ovf.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic [1:0]       dbg_state;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf, dbg_state
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf, dbg_state
  );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock through a
// chain of full-subtractor cells with a registered borrow between digits.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_step;

  logic [DIGIT-1:0] w_d;
  logic             w_c;
  logic             w_c_msb;
  logic             w_last;
  logic [WIDTH-1:0] w_diff_nxt;

  // Ripple the borrow through the DIGIT cells; w_c_msb keeps the borrow entering the top cell.
  always_comb begin
    w_d     = '0;
    w_c     = r_borrow;
    w_c_msb = r_borrow;
    for (int i = 0; i < DIGIT; i++) begin
      w_c_msb = w_c;
      w_d[i]  = r_a[i] ^ r_b[i] ^ w_c;
      w_c     = (~r_a[i] & r_b[i]) | (~r_a[i] & w_c) | (r_b[i] & w_c);
    end
  end

  assign w_last     = (r_step == CW'(STEPS - 1));
  assign w_diff_nxt = (r_diff >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_step   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= bus.bin;
            r_step   <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_diff   <= w_diff_nxt;
          r_borrow <= w_c;
          r_step   <= r_step + 1'b1;
          // The last digit holds the sign bit, so its borrows decide bout and ovf.
          if (w_last) begin
            r_bout  <= w_c;
            r_ovf   <= w_c_msb ^ w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.ovf       = r_ovf;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed tables at WIDTH 1 and 8, held-start
// back-to-back run, mid-operation reset, and a WIDTH=16 random sweep over DIGIT.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  // ---------------- DUT instances ----------------
  serial_subtractor_if #(.WIDTH(1)) if1 ();
  serial_subtractor_if #(.WIDTH(8)) if8a ();
  serial_subtractor_if #(.WIDTH(8)) if8b ();

  serial_subtractor #(.WIDTH(1), .DIGIT(1)) u_w1   (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_w8d1 (.clk(clk), .rst_n(rst_n), .bus(if8a));
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_w8d4 (.clk(clk), .rst_n(rst_n), .bus(if8b));

  logic        s16_start;
  logic [15:0] s16_a;
  logic [15:0] s16_b;
  logic        s16_bin;
  logic [15:0] w16_diff [4];
  logic [3:0]  w16_done;
  logic [3:0]  w16_bout;
  logic [3:0]  w16_ovf;
  int          dg16 [4];

  for (genvar k = 0; k < 4; k++) begin : g16
    localparam int DG = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : 16;
    serial_subtractor_if #(.WIDTH(16)) bus ();
    assign bus.start   = s16_start;
    assign bus.a       = s16_a;
    assign bus.b       = s16_b;
    assign bus.bin     = s16_bin;
    assign w16_diff[k] = bus.diff;
    assign w16_done[k] = bus.done;
    assign w16_bout[k] = bus.bout;
    assign w16_ovf[k]  = bus.ovf;
    serial_subtractor #(.WIDTH(16), .DIGIT(DG)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic void ref_sub(input int w, input longint a, input longint b, input longint bin,
                                  output logic [31:0] d, output logic bo, output logic ov);
    longint half, r, sa, sb, sr;
    half = longint'(1) << (w - 1);
    r    = a - b - bin;
    bo   = (r < 0);
    d    = 32'(r & ((longint'(1) << w) - 1));
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    sr   = sa - sb - bin;
    ov   = (sr < -half) || (sr >= half);
  endfunction

  function automatic vec_t mk(input logic [7:0] a, b, input logic bin,
                              input logic [7:0] d, input logic bo, ov);
    vec_t v;
    v.a = a; v.b = b; v.bin = bin; v.d = d; v.bo = bo; v.ov = ov;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run1(input logic a, b, bin, output logic d, bo, ov, output int lat);
    lat = -1; d = 1'b0; bo = 1'b0; ov = 1'b0;
    @(negedge clk);
    if1.a = a; if1.b = b; if1.bin = bin; if1.start = 1'b1;
    @(posedge clk); @(negedge clk);
    if1.start = 1'b0;
    chk("w1_busy_after_start", 32'(if1.busy), 1);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); @(negedge clk);
      if (if1.done) begin
        lat = n; d = if1.diff[0]; bo = if1.bout; ov = if1.ovf;
        break;
      end
    end
    @(posedge clk); @(negedge clk);
    chk("w1_done_one_cycle", 32'(if1.done), 0);
  endtask

  task automatic run8(input logic [7:0] a, b, input logic bin,
                      output logic [7:0] d, output logic bo, ov, output int lat);
    lat = -1; d = '0; bo = 1'b0; ov = 1'b0;
    @(negedge clk);
    if8a.a = a; if8a.b = b; if8a.bin = bin; if8a.start = 1'b1;
    @(posedge clk); @(negedge clk);
    if8a.start = 1'b0;
    chk("w8_busy_after_start", 32'(if8a.busy), 1);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (if8a.done) begin
        lat = n; d = if8a.diff; bo = if8a.bout; ov = if8a.ovf;
        chk("w8_busy_low_at_done", 32'(if8a.busy), 0);
        break;
      end
    end
    @(posedge clk); @(negedge clk);
    chk("w8_done_one_cycle", 32'(if8a.done), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  vec_t        v1 [8];
  vec_t        v8 [6];
  logic [7:0]  ha [4];
  logic [7:0]  hb [4];
  logic        hbin [4];

  initial begin
    logic        d1, bo, ov, seen;
    logic [7:0]  d8;
    logic [31:0] ed;
    logic        eb, eo;
    int          lat, nd;
    int          cnt [4];
    int          lt [4];
    logic [15:0] cd [4];
    logic        cb [4];
    logic        co [4];
    logic [15:0] ra, rb;
    logic        rbin;

    dg16 = '{1, 2, 4, 16};
    v1[0] = mk(0, 0, 0, 0, 0, 0); v1[1] = mk(0, 0, 1, 1, 1, 0);
    v1[2] = mk(0, 1, 0, 1, 1, 1); v1[3] = mk(0, 1, 1, 0, 1, 0);
    v1[4] = mk(1, 0, 0, 1, 0, 0); v1[5] = mk(1, 0, 1, 0, 0, 1);
    v1[6] = mk(1, 1, 0, 0, 0, 0); v1[7] = mk(1, 1, 1, 1, 1, 0);
    v8[0] = mk(8'h5A, 8'h3C, 0, 8'h1E, 0, 0);
    v8[1] = mk(8'h00, 8'h00, 1, 8'hFF, 1, 0);
    v8[2] = mk(8'h80, 8'h01, 0, 8'h7F, 0, 1);
    v8[3] = mk(8'h7F, 8'hFF, 0, 8'h80, 1, 1);
    v8[4] = mk(8'hFF, 8'hFF, 1, 8'hFF, 1, 0);
    v8[5] = mk(8'h00, 8'hFF, 0, 8'h01, 1, 0);

    if1.start = 1'b0;  if1.a = '0;  if1.b = '0;  if1.bin = 1'b0;
    if8a.start = 1'b0; if8a.a = '0; if8a.b = '0; if8a.bin = 1'b0;
    if8b.start = 1'b0; if8b.a = '0; if8b.b = '0; if8b.bin = 1'b0;
    s16_start = 1'b0;  s16_a = '0;  s16_b = '0;  s16_bin = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(if8a.busy), 0);
    chk("rst_done", 32'(if8a.done), 0);
    chk("rst_diff", 32'(if8a.diff), 0);
    chk("rst_bout", 32'(if8a.bout), 0);
    chk("rst_ovf", 32'(if8a.ovf), 0);
    chk("rst_state", 32'(if8a.dbg_state), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy_no_start", 32'(if8b.busy), 0);

    // WIDTH=1 exhaustive table
    for (int i = 0; i < 8; i++) begin
      run1(v1[i].a[0], v1[i].b[0], v1[i].bin, d1, bo, ov, lat);
      chk($sformatf("w1_diff_%0d", i), 32'(d1), 32'(v1[i].d[0]));
      chk($sformatf("w1_bout_%0d", i), 32'(bo), 32'(v1[i].bo));
      chk($sformatf("w1_ovf_%0d", i), 32'(ov), 32'(v1[i].ov));
      chk($sformatf("w1_latency_%0d", i), 32'(lat), 1);
    end

    // WIDTH=8 DIGIT=1 table including overflow corners
    for (int i = 0; i < 6; i++) begin
      run8(v8[i].a, v8[i].b, v8[i].bin, d8, bo, ov, lat);
      chk($sformatf("w8_diff_%0d", i), 32'(d8), 32'(v8[i].d));
      chk($sformatf("w8_bout_%0d", i), 32'(bo), 32'(v8[i].bo));
      chk($sformatf("w8_ovf_%0d", i), 32'(ov), 32'(v8[i].ov));
      chk($sformatf("w8_latency_%0d", i), 32'(lat), 8);
    end

    // WIDTH=8 DIGIT=4 with start held high; operands change while busy
    for (int i = 0; i < 4; i++) begin
      ha[i] = 8'($urandom_range(0, 255));
      hb[i] = 8'($urandom_range(0, 255));
      hbin[i] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    if8b.a = ha[0]; if8b.b = hb[0]; if8b.bin = hbin[0]; if8b.start = 1'b1;
    nd = 0;
    for (int c = 1; c <= 15 && nd < 3; c++) begin
      @(posedge clk); @(negedge clk);
      if (if8b.done) begin
        ref_sub(8, longint'(ha[nd]), longint'(hb[nd]), longint'(hbin[nd]), ed, eb, eo);
        chk($sformatf("held_done_cycle_%0d", nd), 32'(c), 32'(3 * (nd + 1)));
        chk($sformatf("held_diff_%0d", nd), 32'(if8b.diff), ed);
        chk($sformatf("held_bout_%0d", nd), 32'(if8b.bout), 32'(eb));
        chk($sformatf("held_ovf_%0d", nd), 32'(if8b.ovf), 32'(eo));
        nd++;
        if (nd == 3) if8b.start = 1'b0;
      end else if (if8b.busy) begin
        if8b.a = ha[nd + 1]; if8b.b = hb[nd + 1]; if8b.bin = hbin[nd + 1];
      end
    end
    chk("held_ops_completed", 32'(nd), 3);
    @(posedge clk); @(negedge clk);
    chk("held_idle_after", 32'(if8b.busy), 0);

    // Reset during RUN
    @(negedge clk);
    if8a.a = 8'hF0; if8a.b = 8'h0F; if8a.bin = 1'b0; if8a.start = 1'b1;
    @(posedge clk); @(negedge clk);
    if8a.start = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk);
    #2;
    chk("midrst_was_busy", 32'(if8a.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(if8a.busy), 0);
    chk("midrst_done", 32'(if8a.done), 0);
    chk("midrst_diff", 32'(if8a.diff), 0);
    chk("midrst_bout", 32'(if8a.bout), 0);
    chk("midrst_ovf", 32'(if8a.ovf), 0);
    chk("midrst_state", 32'(if8a.dbg_state), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); @(negedge clk);
      if (if8a.done || if8a.busy) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 0);
    run8(8'hF0, 8'h0F, 1'b0, d8, bo, ov, lat);
    chk("restart_diff", 32'(d8), 32'h0E1);
    chk("restart_bout", 32'(bo), 0);
    chk("restart_ovf", 32'(ov), 0);
    chk("restart_latency", 32'(lat), 8);

    // WIDTH=16 random regression over DIGIT = 1, 2, 4, 16
    for (int v = 0; v < 1000; v++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rbin = 1'($urandom_range(0, 1));
      if (v == 0) begin ra = 16'h8000; rb = 16'h0001; rbin = 1'b0; end
      if (v == 1) begin ra = 16'h0000; rb = 16'hFFFF; rbin = 1'b1; end
      @(negedge clk);
      s16_a = ra; s16_b = rb; s16_bin = rbin; s16_start = 1'b1;
      @(posedge clk); @(negedge clk);
      s16_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        cnt[k] = 0; lt[k] = -1; cd[k] = '0; cb[k] = 1'b0; co[k] = 1'b0;
      end
      for (int c = 1; c <= 18; c++) begin
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          if (w16_done[k]) begin
            cnt[k]++;
            if (lt[k] < 0) begin
              lt[k] = c; cd[k] = w16_diff[k]; cb[k] = w16_bout[k]; co[k] = w16_ovf[k];
            end
          end
        end
      end
      ref_sub(16, longint'(ra), longint'(rb), longint'(rbin), ed, eb, eo);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("r16_latency_d%0d_v%0d", dg16[k], v), 32'(lt[k]), 32'(16 / dg16[k]));
        chk($sformatf("r16_done_width_d%0d_v%0d", dg16[k], v), 32'(cnt[k]), 1);
        chk($sformatf("r16_diff_d%0d_v%0d", dg16[k], v), 32'(cd[k]), ed);
        chk($sformatf("r16_bout_d%0d_v%0d", dg16[k], v), 32'(cb[k]), 32'(eb));
        chk($sformatf("r16_ovf_d%0d_v%0d", dg16[k], v), 32'(co[k]), 32'(eo));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
